tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Shares one free-running prescaler among NCH timing requesters: game logic, frog animation, sprite movement and display refresh.
- Replaces per-consumer clock dividers.
- Each channel has a programmable period in prescaler ticks. Each channel produces a one-cycle tick enable and a 50%-duty square wave, all on the single system clock.
- A global run/pause/stop FSM sequences all channels together so the game can be started, frozen and reset.

Parameters:
- CLK_HZ, 100000000: system clock frequency.
- BASE_HZ, 1000: prescaler tick rate; PRE_MAX = CLK_HZ/BASE_HZ - 1.
- NCH, 4: number of channels.
- PW, 16: period register width, in base ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: IDLE -> RUN.
- stop  in  1  single-cycle pulse: any state -> IDLE.
- pause  in  1  level: freeze while high.
- en  in  NCH  per-channel enable.
- cfg_we  in  1  period write strobe.
- cfg_ch  in  2  channel index for the write.
- cfg_period  in  PW  new period; 0 = channel disabled.
- tick  out  NCH  one-cycle enable pulse per channel.
- sq  out  NCH  square-wave output per channel.
- state  out  2  current state: 00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Single clock domain; all registers are updated on posedge clk.
- Reset, applied in any state:
  - state goes to IDLE.
  - prescaler count, all channel counters, all periods, tick and sq are cleared to 0.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> PAUSE while pause=1.
  - PAUSE -> RUN on the first cycle pause=0.
  - Any state -> IDLE on stop.
  - If stop and start are asserted together, stop wins.
  - start in RUN or PAUSE is ignored.
  - When stop is taken, these are cleared the next cycle: prescaler, channel counters, tick and sq. Periods are retained.
- Prescaler:
  - Counts only in RUN.
  - When count == PRE_MAX it wraps to 0 and asserts internal base_tick for that cycle.
  - In PAUSE it holds its value; it is not cleared.
- Channel i, on a base_tick cycle in RUN:
  - Acts only if en[i]=1 and period[i] != 0.
  - If cnt[i] == period[i]-1: cnt[i] goes to 0, tick[i] goes to 1, and sq[i] toggles.
  - Otherwise cnt[i] increments.
- Channel latency: tick[i] is registered. It is high for exactly one clk in the cycle after the qualifying base_tick cycle, and is 0 in all other cycles.
- Channel rates:
  - tick period = period[i] * (PRE_MAX+1) clk cycles.
  - sq period is twice the tick period.
- Period of 1: tick on every base_tick.
- Disabled channel (en[i]=0 or period[i]=0):
  - cnt[i] is held at 0, tick[i] stays 0, and sq[i] holds its last value.
- Config write:
  - When cfg_we=1 and cfg_ch < NCH, period[cfg_ch] takes cfg_period next cycle and cnt[cfg_ch] is cleared.
  - A tick for that channel that would fire in the same cycle is suppressed.
  - Writes are accepted in every state.
  - A write with cfg_ch >= NCH is ignored.
- Counter widths:
  - Prescaler width is clog2(PRE_MAX+1).
  - Channel counters are PW bits and never exceed period-1, so they do not wrap.
- pause asserted in IDLE has no effect.
- Ticks of different channels may coincide in the same cycle; they are independent.

Test Plan (bench uses CLK_HZ=100, BASE_HZ=10, so PRE_MAX=9):
1. Reset, write ch0 period=3, en=0001, start pulse:
   - state goes to 01 next cycle.
   - tick[0] pulses every 30 clk.
   - sq[0] toggles at each tick, giving a 60-clk period.
2. Channels ch1=1 and ch2=2, both enabled:
   - tick[1] fires every 10 clk, tick[2] every 20 clk.
   - Every second tick[1] pulse lands in the same cycle as a tick[2] pulse.
3. pause held high for 25 clk mid-count:
   - state is 10 and no ticks occur during the pause.
   - After release, the next tick[0] arrives exactly 25 clk later than its unpaused time.
4. stop and start asserted in the same cycle while in RUN:
   - state goes to 00 and tick and sq clear.
   - Periods are retained: a later start gives the same 30-clk cadence with no re-write.
5. cfg_we for ch0 with period=5 in the same cycle ch0 would tick:
   - No tick in that cycle.
   - The next tick[0] follows 50 clk after the write.
   - A write with cfg_ch=3 while NCH=3 is ignored.
6. rst asserted mid-RUN:
   - Next cycle: state=00, tick=0, sq=0, and all periods are 0.
   - A start with no config writes produces no ticks.

Source files
------------

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//   One free-running prescaler shared by NCH timing channels. Each channel
//   divides the prescaler's base tick by a programmable period. It produces a
//   one-cycle tick enable and a 50%-duty square wave. A global IDLE/RUN/PAUSE
//   state machine starts, freezes and stops all channels together.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       pulse, IDLE -> RUN
//   stop        pulse, any state -> IDLE (wins over start)
//   pause       level, freezes prescaler and channels while in RUN/PAUSE
//   en          per-channel enable
//   cfg_we      period write strobe
//   cfg_ch      channel index for the write (indices >= NCH are ignored)
//   cfg_period  new period in base ticks, 0 disables the channel
//   tick        per-channel one-cycle enable pulse (registered)
//   sq          per-channel square wave, toggles on every tick
//   state       00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module tick_scheduler #(
    parameter int CLK_HZ  = 100000000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int PW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           pause,
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [1:0]     state
);

    localparam int PRE_MAX = CLK_HZ / BASE_HZ - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t           cur;
    logic [PRE_W-1:0] pre;
    logic [PW-1:0]    period [NCH];
    logic [PW-1:0]    cnt    [NCH];
    logic             base_tick;
    logic [NCH-1:0]   wr_sel;

    // The base tick only exists while running, so PAUSE freezes everything.
    assign base_tick = (cur == S_RUN) && (pre == PRE_W'(PRE_MAX));
    assign state     = cur;

    // Decode the config write; an out-of-range index selects no channel.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= S_IDLE;
            pre  <= '0;
            tick <= '0;
            sq   <= '0;
            for (int i = 0; i < NCH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            // Global state machine; stop has priority over everything.
            if (stop) begin
                cur <= S_IDLE;
            end else begin
                case (cur)
                    S_IDLE:  if (start) cur <= S_RUN;
                    S_RUN:   if (pause) cur <= S_PAUSE;
                    S_PAUSE: if (!pause) cur <= S_RUN;
                    default: cur <= S_IDLE;
                endcase
            end

            // Prescaler advances only in RUN and holds through PAUSE.
            if (stop) begin
                pre <= '0;
            end else if (cur == S_RUN) begin
                pre <= base_tick ? '0 : pre + PRE_W'(1);
            end

            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
                if (wr_sel[i]) begin
                    period[i] <= cfg_period;
                end

                if (stop) begin
                    cnt[i] <= '0;
                    sq[i]  <= 1'b0;
                end else if (wr_sel[i]) begin
                    // A rewrite restarts the channel and swallows any tick
                    // that would have fired on this edge.
                    cnt[i] <= '0;
                end else if (!en[i] || period[i] == '0) begin
                    cnt[i] <= '0;
                end else if (base_tick) begin
                    if (cnt[i] == period[i] - PW'(1)) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
                        sq[i]   <= ~sq[i];
                    end else begin
                        cnt[i] <= cnt[i] + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_scheduler
//   Bench for tick_scheduler with CLK_HZ=100, BASE_HZ=10 (10 clk per base
//   tick) and NCH=3. A vector table covers the basic cadence and coincident
//   channels. Hand-written sequences cover pause, stop+start, write
//   suppression and mid-run reset. A randomized phase is checked every cycle
//   against a behavioural model that counts run cycles and base ticks.
// -----------------------------------------------------------------------------
module tb_tick_scheduler;

    localparam int NCH = 3;
    localparam int PW  = 16;
    localparam int DIV = 10;

    logic           clk = 1'b0;
    logic           rst, start, stop, pause, cfg_we;
    logic [NCH-1:0] en;
    logic [1:0]     cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic [NCH-1:0] tick, sq;
    logic [1:0]     state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    tick_scheduler #(
        .CLK_HZ (100),
        .BASE_HZ(10),
        .NCH    (NCH),
        .PW     (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .tick      (tick),
        .sq        (sq),
        .state     (state)
    );

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        rst    = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    // Steps until tick[ch] is seen; n is the number of steps taken, or
    // limit when the tick never came.
    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < limit);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string          name;
        logic           r, s, p_stop, ps;
        logic [NCH-1:0] e;
        logic           w;
        logic [1:0]     c;
        logic [PW-1:0]  per;
        int             n;
        logic [1:0]     exp_state;
        logic [NCH-1:0] exp_tick, exp_sq;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic r, input logic s,
                                input logic p_stop, input logic ps,
                                input logic [NCH-1:0] e, input logic w,
                                input logic [1:0] c, input logic [PW-1:0] per,
                                input int n, input logic [1:0] es,
                                input logic [NCH-1:0] et, input logic [NCH-1:0] esq);
        vec_t v;
        v.name = nm; v.r = r; v.s = s; v.p_stop = p_stop; v.ps = ps;
        v.e = e; v.w = w; v.c = c; v.per = per; v.n = n;
        v.exp_state = es; v.exp_tick = et; v.exp_sq = esq;
        return v;
    endfunction

    // ---------------- reference model state ----------------
    int             m_state, m_r;
    int             m_b   [NCH];
    int             m_per [NCH];
    logic [NCH-1:0] m_tick, m_sq;

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic           bt;
        logic [NCH-1:0] nt;
        if (rst) begin
            m_state = 0; m_r = 0; m_tick = '0; m_sq = '0;
            for (int i = 0; i < NCH; i++) begin m_b[i] = 0; m_per[i] = 0; end
        end else begin
            bt = (m_state == 1) && (m_r % DIV == DIV - 1);
            nt = '0;
            for (int i = 0; i < NCH; i++) begin
                if (stop || (cfg_we && int'(cfg_ch) == i) || !en[i] || m_per[i] == 0) begin
                    m_b[i] = 0;
                end else if (bt) begin
                    m_b[i]++;
                    if (m_b[i] % m_per[i] == 0) begin
                        nt[i]   = 1'b1;
                        m_sq[i] = ~m_sq[i];
                    end
                end
                if (cfg_we && int'(cfg_ch) == i) m_per[i] = int'(cfg_period);
            end
            m_tick = nt;
            if (stop) begin
                m_sq = '0; m_r = 0; m_state = 0;
            end else begin
                if (m_state == 1) m_r++;
                case (m_state)
                    0: if (start) m_state = 1;
                    1: if (pause) m_state = 2;
                    default: if (!pause) m_state = 1;
                endcase
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs[$];
        int   n;
        logic [NCH-1:0] any_tick;

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;

        // Table: ch0 period 3 cadence, then ch1=1 / ch2=2 coincidences.
        vecs.push_back(mk("reset",       1,0,0,0,3'b000,0,0,0, 1,2'b00,3'b000,3'b000));
        vecs.push_back(mk("cfg_ch0",     0,0,0,0,3'b001,1,0,3, 1,2'b00,3'b000,3'b000));
        vecs.push_back(mk("start",       0,1,0,0,3'b001,0,0,0, 1,2'b01,3'b000,3'b000));
        vecs.push_back(mk("pre_tick0",   0,0,0,0,3'b001,0,0,0,29,2'b01,3'b000,3'b000));
        vecs.push_back(mk("tick0_a",     0,0,0,0,3'b001,0,0,0, 1,2'b01,3'b001,3'b001));
        vecs.push_back(mk("after_tick0", 0,0,0,0,3'b001,0,0,0, 1,2'b01,3'b000,3'b001));
        vecs.push_back(mk("tick0_b",     0,0,0,0,3'b001,0,0,0,29,2'b01,3'b001,3'b000));
        vecs.push_back(mk("tick0_c",     0,0,0,0,3'b001,0,0,0,30,2'b01,3'b001,3'b001));
        vecs.push_back(mk("cfg_ch1",     0,0,0,0,3'b111,1,1,1, 1,2'b01,3'b000,3'b001));
        vecs.push_back(mk("cfg_ch2",     0,0,0,0,3'b111,1,2,2, 1,2'b01,3'b000,3'b001));
        vecs.push_back(mk("t100",        0,0,0,0,3'b111,0,0,0, 8,2'b01,3'b010,3'b011));
        vecs.push_back(mk("t110",        0,0,0,0,3'b111,0,0,0,10,2'b01,3'b110,3'b101));
        vecs.push_back(mk("t120",        0,0,0,0,3'b111,0,0,0,10,2'b01,3'b011,3'b110));
        vecs.push_back(mk("t130",        0,0,0,0,3'b111,0,0,0,10,2'b01,3'b110,3'b000));
        vecs.push_back(mk("t131",        0,0,0,0,3'b111,0,0,0, 1,2'b01,3'b000,3'b000));

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].r; start = vecs[k].s; stop = vecs[k].p_stop;
            pause = vecs[k].ps; en = vecs[k].e; cfg_we = vecs[k].w;
            cfg_ch = vecs[k].c; cfg_period = vecs[k].per;
            step();
            clear_pulses();
            for (int j = 1; j < vecs[k].n; j++) step();
            check({vecs[k].name, "_state"}, int'(state), int'(vecs[k].exp_state));
            check({vecs[k].name, "_tick"},  int'(tick),  int'(vecs[k].exp_tick));
            check({vecs[k].name, "_sq"},    int'(sq),    int'(vecs[k].exp_sq));
        end

        // Pause for 25 clk mid-count: tick moves from 30 to 55.
        rst = 1'b1; step(); clear_pulses();
        en = 3'b001; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd3; step(); clear_pulses();
        start = 1'b1; step(); clear_pulses();
        repeat (10) step();
        pause = 1'b1;
        for (int j = 0; j < 25; j++) begin
            step();
            check("pause_state", int'(state), 2);
            check("pause_no_tick", int'(tick), 0);
        end
        pause = 1'b0;
        wait_tick(0, 100, n);
        check("pause_delay", n, 20);
        check("pause_sq", int'(sq[0]), 1);

        // stop and start together: stop wins, periods survive.
        repeat (5) step();
        stop = 1'b1; start = 1'b1; step(); clear_pulses();
        check("stop_state", int'(state), 0);
        check("stop_tick", int'(tick), 0);
        check("stop_sq", int'(sq), 0);
        repeat (3) step();
        check("stop_stays_idle", int'(state), 0);
        start = 1'b1; step(); clear_pulses();
        check("restart_state", int'(state), 1);
        wait_tick(0, 100, n);
        check("restart_first", n, 30);
        wait_tick(0, 100, n);
        check("restart_second", n, 30);
        check("restart_sq", int'(sq[0]), 0);

        // Write to ch0 on the edge it would tick: suppressed, restart at 5.
        repeat (29) step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd5; step(); clear_pulses();
        check("cfg_suppress", int'(tick), 0);
        check("cfg_suppress_sq", int'(sq[0]), 0);
        repeat (5) step();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd1; step(); clear_pulses();
        wait_tick(0, 100, n);
        check("cfg_first_after_write", n, 44);
        check("cfg_sq", int'(sq[0]), 1);
        wait_tick(0, 100, n);
        check("cfg_period5", n, 50);

        // Mid-run reset clears periods, so a bare start yields no ticks.
        rst = 1'b1; step(); clear_pulses();
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_sq", int'(sq), 0);
        en = 3'b111; start = 1'b1; step(); clear_pulses();
        check("rst_restart_state", int'(state), 1);
        any_tick = '0;
        for (int j = 0; j < 40; j++) begin
            step();
            any_tick |= tick;
        end
        check("rst_no_ticks", int'(any_tick), 0);

        // Randomized phase against the behavioural model.
        pause = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            rst        = (it == 0) || ($urandom_range(0, 499) == 0);
            stop       = ($urandom_range(0, 199) == 0);
            start      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) en = NCH'($urandom_range(0, 7));
            cfg_we     = ($urandom_range(0, 24) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = PW'($urandom_range(0, 4));
            model_step();
            step();
            check("rand_state", int'(state), m_state);
            check("rand_tick", int'(tick), int'(m_tick));
            check("rand_sq", int'(sq), int'(m_sq));
            clear_pulses();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
